// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count,
// almost/full/empty flags, last-entry pulses and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int FIFO_SIZE          = 3,
  parameter int DATA_WIDTH         = 8,
  parameter int ALMOST_FULL_LEVEL  = (1 << FIFO_SIZE) - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [FIFO_SIZE:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pushed_last,
  output logic                  popped_last,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = FIFO_SIZE;
  localparam int CW = FIFO_SIZE + 1;
  localparam logic [FIFO_SIZE:0] DEPTH = CW'(1 << FIFO_SIZE);
  localparam logic [FIFO_SIZE:0] AF_LVL = CW'(ALMOST_FULL_LEVEL);
  localparam logic [FIFO_SIZE:0] AE_LVL = CW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [2**FIFO_SIZE];
  logic [FIFO_SIZE-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_SIZE:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  pushed_last_q, pushed_last_d, popped_last_q, popped_last_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  act, pop_acc, push_acc;

  assign full         = count_q == DEPTH;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_LVL;
  assign almost_empty = count_q <= AE_LVL;
  assign count        = count_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign pushed_last  = pushed_last_q;
  assign popped_last  = popped_last_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign act      = enable & ~clear;
  assign pop_acc  = act & pop & ~empty;
  assign push_acc = act & push & (~full | pop_acc);

  always_comb begin
    wr_ptr_d      = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = (push_acc & ~pop_acc) ? count_q + CW'(1) :
                    (pop_acc & ~push_acc) ? count_q - CW'(1) : count_q;
    out_data_d    = pop_acc ? mem[rd_ptr_q] : out_data_q;
    out_valid_d   = enable ? pop_acc : out_valid_q;
    pushed_last_d = enable ? (push_acc & ~pop_acc & (count_q == DEPTH - CW'(1))) : pushed_last_q;
    popped_last_d = enable ? (pop_acc & ~push_acc & (count_q == CW'(1))) : popped_last_q;
    overflow_d    = overflow_q | (act & push & full & ~pop_acc);
    underflow_d   = underflow_q | (act & pop & empty);
    if (enable && clear) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      out_valid_d   = 1'b0;
      pushed_last_d = 1'b0;
      popped_last_d = 1'b0;
      overflow_d    = 1'b0;
      underflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      pushed_last_q <= 1'b0;
      popped_last_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      pushed_last_q <= pushed_last_d;
      popped_last_q <= popped_last_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end
endmodule
